ascii_display_scanner: RTL and testbench
========================================

Name: ascii_display_scanner

Overview:
- Upstream feeder for the ASCII-to-7-segment decoder: accepts ASCII bytes over a valid/ready stream, holds the last NUM_DIGITS characters in a marquee buffer, and time-multiplexes them onto a common-anode multi-digit display.
- Presents one character per scan slot on char_out for the decoder and drives the matching active-low anode.
- Interprets backspace (8'h08) and carriage return (8'h0D) as edit commands.

Parameters:
- CLK_DIV, 100000: clocks per digit scan slot; must be ≥2.
- NUM_DIGITS, 4: number of display digits and buffer entries; must be ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data holds a byte to accept.
- in_data  input  8  ASCII byte.
- in_ready  output  1  block can accept; combinational = (state==IDLE) && !clear.
- clear  input  1  synchronous single-cycle request to blank the buffer.
- char_out  output  8  ASCII character for the active digit; feeds the decoder's hex input.
- an  output  NUM_DIGITS  anode enables, active-low, one-hot-zero.
- busy  output  1  high while in CLEAR state.

Behaviour:
- Reset is asynchronous and active-low; all state clears immediately on rst_n low.
- Reset values:
  - buffer entries all 8'h20 (space);
  - state IDLE; prescaler 0; digit index 0;
  - an = all ones except bit0 = 0;
  - char_out = 8'h20; busy = 0.
- Buffer indexing: entry 0 is the rightmost digit (an[0]).
- Handshake: a transfer occurs on a rising edge where in_valid && in_ready. in_data must stay stable while in_valid is high and in_ready is low. Back-to-back transfers on consecutive cycles are supported.
- Accepted byte, any value other than 8'h08 or 8'h0D:
  - shift left: entry[k] <= entry[k-1] for k = NUM_DIGITS-1..1;
  - entry[0] <= in_data;
  - the oldest character (entry[NUM_DIGITS-1]) is discarded;
  - no filtering of unprintable bytes (the decoder shows its default glyph).
- Accepted 8'h08 (backspace):
  - shift right: entry[k] <= entry[k+1];
  - entry[NUM_DIGITS-1] <= 8'h20;
  - on an all-space buffer the result is still all spaces.
- Accepted 8'h0D (carriage return): identical to a clear request.
- State machine:
  - IDLE --(clear, or accepted 8'h0D)--> CLEAR.
  - CLEAR: clear counter runs 0..NUM_DIGITS-1 and writes 8'h20 to entry[counter] each cycle.
  - CLEAR --(last entry written)--> IDLE. CLEAR lasts exactly NUM_DIGITS cycles.
- Outputs during CLEAR: in_ready = 0; busy = 1.
- clear asserted while in CLEAR is ignored; it does not restart the clear counter.
- clear and in_valid in the same IDLE cycle: in_ready is 0 that cycle, so no transfer occurs and the byte stays pending.
- Scan:
  - prescaler counts 0..CLK_DIV-1 and wraps;
  - at terminal count the digit index advances by one and wraps from NUM_DIGITS-1 to 0;
  - an is registered: an <= ~(1 << next_index), updated on the same edge as the index, so exactly one bit of an is low in every cycle.
- char_out: registered, char_out <= entry[index] every cycle. Buffer or index changes appear on char_out 1 cycle later; the one-cycle skew against an is accepted.
- Scanning runs continuously, independent of state and of the handshake.
- Reset mid-CLEAR or mid-transfer aborts: all state returns to reset values and any pending byte is dropped.

Test Plan:
- Reset values: hold rst_n low with clk toggling → an = 4'b1110, char_out = 8'h20, in_ready = 1, busy = 0. Release rst_n → in_ready = 1 on the first cycle.
- Marquee fill (CLK_DIV=4): send "A", "B", "C", "D" back-to-back → buffer {3:41, 2:42, 1:43, 0:44}. Over one 16-cycle frame, char_out reads 44, 43, 42, 41 with an = 1110, 1101, 1011, 0111, one clock later than each anode change.
- Overflow: after "ABCD", send "E" → buffer {42, 43, 44, 45}; 'A' is discarded.
- Backspace: after "ABCD", send 8'h08 → buffer {20, 41, 42, 43}. Five more 8'h08 bytes → all 8'h20.
- Clear and CR: pulse clear with in_valid = 1 and in_data = 8'h31 in the same cycle:
  - in_ready = 0 for 1 + 4 cycles; busy = 1 for 4 cycles;
  - buffer ends all 8'h20; then 8'h31 is accepted into entry[0].
  - Repeat using in_data = 8'h0D → same 4-cycle clear.
- Reset mid-clear: assert rst_n low during CLEAR cycle 2 → busy = 0 and the buffer is all 8'h20 immediately. The scan restarts at digit 0 with prescaler 0.

Source files
------------

// File: rtl/ascii_display_scanner_if.sv
// ----------------------------------------------------------------------------
// ascii_display_scanner_if
//   Byte stream into the display scanner.
//
//   Handshake: a byte moves on a rising clk edge where in_valid && in_ready.
//   While in_valid is high and in_ready is low the master holds in_data
//   steady. The master may not make in_valid depend on in_ready. in_ready may
//   drop for a cycle with no warning, for example during a clear request.
//
//   Signals:
//     in_valid  master -> slave   in_data holds a byte
//     in_data   master -> slave   ASCII byte
//     in_ready  slave  -> master  slave can take the byte this cycle
// ----------------------------------------------------------------------------
interface ascii_display_scanner_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/ascii_display_scanner.sv
// ----------------------------------------------------------------------------
// ascii_display_scanner
//   Keeps the last NUM_DIGITS ASCII characters from a byte stream in a marquee
//   buffer. It time-multiplexes the characters onto a common-anode display.
//   Each scan slot lasts CLK_DIV clocks. For each slot the block puts the
//   character on char_out for the 7-segment decoder and drives one anode low.
//   Byte 8'h08 (backspace) removes the newest character. Byte 8'h0D (carriage
//   return) blanks the buffer, which the clear input also does.
//
//   Ports:
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     s_if       byte stream (slave side): in_valid, in_data, in_ready
//     clear      single-cycle request to blank the buffer
//     char_out   character for the active digit (one cycle behind an)
//     an         anode enables, active-low, exactly one bit low
//     busy       high while the buffer is being blanked
//     state_dbg  current FSM state (0 = IDLE, 1 = CLEAR)
// ----------------------------------------------------------------------------
module ascii_display_scanner #(
  parameter int CLK_DIV    = 100000,
  parameter int NUM_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ascii_display_scanner_if.slave s_if,
  input  logic                  clear,
  output logic [7:0]            char_out,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  busy,
  output logic                  state_dbg
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] BKSP  = 8'h08;
  localparam logic [7:0] CR    = 8'h0D;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [IW-1:0]         clr_cnt_q, clr_cnt_d;
  logic [7:0]            ent_q [NUM_DIGITS];
  logic [7:0]            ent_d [NUM_DIGITS];
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0]            char_q, char_d;
  logic                  in_ready;
  logic                  transfer;

  assign in_ready      = (state_q == ST_IDLE) && !clear;
  assign transfer      = s_if.in_valid && in_ready;
  assign s_if.in_ready = in_ready;
  assign busy          = (state_q == ST_CLEAR);
  assign state_dbg     = state_q;
  assign an            = an_q;
  assign char_out      = char_q;

  // Buffer edit and clear sequencing
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ent_d     = ent_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else if (transfer) begin
          if (s_if.in_data == CR) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
          end else if (s_if.in_data == BKSP) begin
            // Drop the newest character; a space enters at the left.
            for (int k = 0; k < NUM_DIGITS - 1; k++) ent_d[k] = ent_q[k+1];
            ent_d[NUM_DIGITS-1] = SPACE;
          end else begin
            // Marquee: the new byte enters on the right, the oldest is lost.
            for (int k = NUM_DIGITS - 1; k > 0; k--) ent_d[k] = ent_q[k-1];
            ent_d[0] = s_if.in_data;
          end
        end
      end
      ST_CLEAR: begin
        // One entry per cycle. A clear request here does not restart the count.
        ent_d[clr_cnt_q] = SPACE;
        if (clr_cnt_q == IW'(NUM_DIGITS - 1)) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Scan: the prescaler moves the digit index. The anode is registered on the
  // same edge as the index, from the index value being loaded. char_out reads
  // the current index, so it trails the anode by one clock.
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    an_d    = an_q;
    char_d  = ent_q[idx_q];
    if (presc_q == PW'(CLK_DIV - 1)) begin
      presc_d = '0;
      idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) an_d[k] = (idx_d != IW'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
      for (int k = 0; k < NUM_DIGITS; k++) ent_q[k] <= SPACE;
      presc_q   <= '0;
      idx_q     <= '0;
      an_q      <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
      char_q    <= SPACE;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      for (int k = 0; k < NUM_DIGITS; k++) ent_q[k] <= ent_d[k];
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      an_q      <= an_d;
      char_q    <= char_d;
    end
  end

endmodule

// File: tb/tb_ascii_display_scanner.sv
// ----------------------------------------------------------------------------
// tb_ascii_display_scanner
//   Bench for ascii_display_scanner with CLK_DIV=4 and NUM_DIGITS=4.
//   A reference model holds the marquee as a byte queue and tracks time as a
//   cycle count. On each rising edge it pushes the expected {an, char_out,
//   busy} into exp_q. A monitor on the falling edge pops the queue and
//   compares the entry with the DUT outputs.
// ----------------------------------------------------------------------------
module tb_ascii_display_scanner;

  localparam int CLK_DIV = 4;
  localparam int N       = 4;
  localparam int W       = N + 8 + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic [7:0]   char_out;
  logic [N-1:0] an;
  logic         busy;
  logic         state_dbg;

  ascii_display_scanner_if sif();

  ascii_display_scanner #(.CLK_DIV(CLK_DIV), .NUM_DIGITS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_if      (sif),
    .clear     (clear),
    .char_out  (char_out),
    .an        (an),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / check ----------------
  int n_vec = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   m_q [$];     // m_q[0] is the rightmost digit
  int           m_t;         // clock edges since reset was released
  int           m_clr_left;  // CLEAR cycles remaining
  logic [W-1:0] exp_q [$];
  int           pd, nd;
  logic [N-1:0] ea;
  logic [7:0]   ec;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      for (int i = 0; i < N; i++) m_q.push_back(8'h20);
      m_t        = 0;
      m_clr_left = 0;
      exp_q.delete();
    end else begin
      // char_out shows the digit that was active before this edge, read from
      // the buffer as it was before this edge.
      pd = (m_t / CLK_DIV) % N;
      ec = m_q[pd];
      m_t++;
      nd = (m_t / CLK_DIV) % N;
      ea = '1;
      ea[nd] = 1'b0;
      if (m_clr_left > 0) begin
        m_q[N - m_clr_left] = 8'h20;
        m_clr_left--;
      end else if (clear) begin
        m_clr_left = N;
      end else if (sif.in_valid) begin
        case (sif.in_data)
          8'h0D: m_clr_left = N;
          8'h08: begin void'(m_q.pop_front()); m_q.push_back(8'h20); end
          default: begin m_q.push_front(sif.in_data); void'(m_q.pop_back()); end
        endcase
      end
      exp_q.push_back({ea, ec, (m_clr_left > 0)});
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] got_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_an",    32'(an),       32'(4'b1110));
      chk("rst_char",  32'(char_out), 32'h20);
      chk("rst_busy",  32'(busy),     32'h0);
      chk("rst_ready", 32'(sif.in_ready), 32'(!clear));
    end else begin
      chk("in_ready", 32'(sif.in_ready), 32'((m_clr_left == 0) && !clear));
      if (exp_q.size() == 0) begin
        n_vec++;
        n_mis++;
        $display("FAIL sb_empty at %0t: got no expected entry, expected one", $time);
      end else begin
        got_e = exp_q.pop_front();
        chk("an",       32'(an),       32'(got_e[W-1 -: N]));
        chk("char_out", 32'(char_out), 32'(got_e[8:1]));
        chk("busy",     32'(busy),     32'(got_e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] d);
    int   n;
    logic ok;
    sif.in_valid = 1'b1;
    sif.in_data  = d;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = sif.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    sif.in_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_mis++;
      $display("FAIL send_timeout: byte %h not accepted in 100 cycles", d);
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic clear_with_byte(input logic [7:0] d);
    sif.in_valid = 1'b1;
    sif.in_data  = d;
    clear        = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    send_byte(d);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    sif.in_valid = 1'b0;
    clear        = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n        = 1'b0;
    clear        = 1'b0;
    sif.in_valid = 1'b0;
    sif.in_data  = 8'h00;
    do_reset();

    // Marquee fill, then a full frame of scanning
    send_str("ABCD");
    idle(2 * CLK_DIV * N);
    // Overflow drops 'A'
    send_byte(8'h45);
    idle(CLK_DIV * N);

    // Backspace series
    do_reset();
    send_str("ABCD");
    send_byte(8'h08);
    idle(CLK_DIV * N);
    repeat (5) send_byte(8'h08);
    idle(CLK_DIV * N);

    // Clear with a pending byte, then the same with carriage return
    send_str("WXYZ");
    clear_with_byte(8'h31);
    idle(CLK_DIV * N);
    send_str("PQ");
    clear_with_byte(8'h0D);
    send_byte(8'h0D);
    idle(CLK_DIV * N + 2);

    // Reset during CLEAR cycle 2
    send_str("KLMN");
    pulse_clear();      // CLEAR starts on this edge
    idle(1);            // CLEAR cycle 2 is now in progress
    rst_n = 1'b0;
    #1;
    chk("midclr_busy", 32'(busy),     32'h0);
    chk("midclr_an",   32'(an),       32'(4'b1110));
    chk("midclr_char", 32'(char_out), 32'h20);
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(CLK_DIV * N);

    // Random traffic
    for (int i = 0; i < 250; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 0)      pulse_clear();
      else if (r == 1) send_byte(8'h08);
      else if (r == 2) send_byte(8'h0D);
      else if (r == 3) clear_with_byte(8'($urandom_range(0, 255)));
      else             send_byte(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(2 * CLK_DIV * N);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
